// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its busy scoreboard.
//   DATA_W_DEF / NUM_REGS_DEF : default register width and depth
//   reg_addr_t                : register address at the default depth
//   ZERO_REG                  : index of the hardwired-zero register
//   addr_in_range()           : true when an address names a writable register
package regfile_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int NUM_REGS_DEF = 8;
   localparam int ZERO_REG     = 0;

   typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;

   // Address is non-zero and below the register count. The address is
   // zero-extended to int before the compare.
   function automatic logic addr_in_range(input int addr, input int num_regs);
      return (addr != ZERO_REG) && (addr < num_regs);
   endfunction

endpackage

// File: rtl/reg_busy_table.sv
// Per-register busy scoreboard for read-after-write hazard detection.
//   clock, reset            : clock and synchronous active-high reset
//   rd_addr1/2              : read addresses to look up
//   wr_en/wr_addr           : writeback, clears the destination busy bit
//   issue_en/issue_addr     : issue, sets the destination busy bit
//   busy1/2                 : lookup result per read port (bypass-masked)
//   busy_vec                : raw scoreboard state, bit 0 always 0
module reg_busy_table
   import regfile_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int BYPASS   = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   rd_addr1,
   input  logic [ADDR_W-1:0]   rd_addr2,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic                issue_en,
   input  logic [ADDR_W-1:0]   issue_addr,
   output logic                busy1,
   output logic                busy2,
   output logic [NUM_REGS-1:0] busy_vec
);

   // Lookup vector padded to the full address space so out-of-range
   // addresses index a constant zero instead of falling off the end.
   localparam int NPOW = 1 << ADDR_W;

   logic [NUM_REGS-1:0] busy;
   logic [NPOW-1:0]     busy_ext;
   logic                fwd1, fwd2;

   assign busy[0] = 1'b0;

   for (genvar i = 1; i < NUM_REGS; i++) begin : g_busy
      logic q;
      // Set beats clear: a newly issued producer supersedes the one
      // whose result is being written back this cycle.
      always_ff @(posedge clock) begin
         if (reset)
            q <= 1'b0;
         else if (issue_en && issue_addr == ADDR_W'(i))
            q <= 1'b1;
         else if (wr_en && wr_addr == ADDR_W'(i))
            q <= 1'b0;
      end
      assign busy[i] = q;
   end

   assign busy_ext = NPOW'(busy);

   // A same-cycle writeback to the read address forwards final data, so
   // the consumer need not stall.
   assign fwd1 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr1);
   assign fwd2 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr2);

   assign busy1    = busy_ext[rd_addr1] & ~fwd1;
   assign busy2    = busy_ext[rd_addr2] & ~fwd2;
   assign busy_vec = busy;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with synchronous clear, write-to-read bypass
// and a busy scoreboard for multi-cycle producers.
//   clock, reset          : clock and synchronous active-high reset
//   rd_addr1/2, rd_data1/2: combinational read ports (R0 and out-of-range read 0)
//   wr_en/wr_addr/wr_data : writeback port
//   issue_en/issue_addr   : marks a destination busy at issue
//   busy1/2, hazard       : per-port busy lookup and their OR
//   busy_vec              : raw scoreboard state
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_W   = DATA_W_DEF,
   parameter  int NUM_REGS = NUM_REGS_DEF,
   parameter  int BYPASS   = 1,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   rd_addr1,
   input  logic [ADDR_W-1:0]   rd_addr2,
   output logic [DATA_W-1:0]   rd_data1,
   output logic [DATA_W-1:0]   rd_data2,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                issue_en,
   input  logic [ADDR_W-1:0]   issue_addr,
   output logic                busy1,
   output logic                busy2,
   output logic                hazard,
   output logic [NUM_REGS-1:0] busy_vec
);

   logic [DATA_W-1:0]            rf [NUM_REGS];
   logic                         wr_ok;
   logic [1:0][ADDR_W-1:0]       rd_addr;
   logic [1:0][DATA_W-1:0]       rd_data;

   assign wr_ok = wr_en && addr_in_range(int'(wr_addr), NUM_REGS);

   // R0 is never written, so its flop stays at the reset value of zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (wr_ok) begin
         rf[wr_addr] <= wr_data;
      end
   end

   assign rd_addr[0] = rd_addr1;
   assign rd_addr[1] = rd_addr2;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      always_comb begin
         rd_data[p] = '0;
         if (addr_in_range(int'(rd_addr[p]), NUM_REGS)) begin
            if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr[p]))
               rd_data[p] = wr_data;
            else
               rd_data[p] = rf[rd_addr[p]];
         end
      end
   end

   assign rd_data1 = rd_data[0];
   assign rd_data2 = rd_data[1];

   reg_busy_table #(
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS)
   ) u_busy (
      .clock      (clock),
      .reset      (reset),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .issue_en   (issue_en),
      .issue_addr (issue_addr),
      .busy1      (busy1),
      .busy2      (busy2),
      .busy_vec   (busy_vec)
   );

   assign hazard = busy1 | busy2;

endmodule
